// File: rtl/bitslice_alu_n_if.sv
// Operand, control and flag bundle of the bitslice ALU.
// The tri-state y bus and the bidirectional shift ports stay plain ports on the ALU.
interface bitslice_alu_n_if #(
    parameter int WIDTH  = 8,
    parameter int RAM_AW = 4
);
    logic [RAM_AW-1:0] a;
    logic [RAM_AW-1:0] b;
    logic [8:0]        i;
    logic [WIDTH-1:0]  din;
    logic              oe_;
    logic              cn;
    logic              stl;
    logic              ovr;
    logic              f0;
    logic              fn;
    logic              cn4;
    logic              g_;
    logic              p_;
    logic [3:0]        st;

    modport master (
        output a, b, i, din, oe_, cn, stl,
        input  ovr, f0, fn, cn4, g_, p_, st
    );

    modport slave (
        input  a, b, i, din, oe_, cn, stl,
        output ovr, f0, fn, cn4, g_, p_, st
    );
endinterface

// File: rtl/bitslice_alu_n.sv
// WIDTH-bit bitslice ALU: two-port register file, Q register, up/down
// double-length shifter, group carry lookahead and a latched Z/N/C/V status.
// Datapath and flags are combinational; all state changes on the rising cp edge.
module bitslice_alu_n #(
    parameter int WIDTH  = 8,
    parameter int RAM_AW = 4
) (
    input  logic             cp,
    input  logic             rst,
    bitslice_alu_n_if.slave  bus,
    inout  wire              q0,
    inout  wire              qn,
    inout  wire              ram0,
    inout  wire              ramn,
    output wire [WIDTH-1:0]  y
);
    localparam int DEPTH = 2 ** RAM_AW;

    logic [WIDTH-1:0] ram_q [DEPTH];
    logic [WIDTH-1:0] ram_d [DEPTH];
    logic [WIDTH-1:0] q_q, q_d;
    logic [3:0]       st_q, st_d;

    logic [2:0]       src_s, fun_s, dst_s;
    logic [WIDTH-1:0] a_s, b_s, r_s, s_s, r_eff_s, s_eff_s, f_s, y_s;
    logic [WIDTH:0]   sum_s;
    logic             gg_s, c_msb_s, ovr_s, cn4_s, f0_s, fn_s, g_n_s, p_n_s;
    logic             down_s, up_s;

    assign src_s = bus.i[2:0];
    assign fun_s = bus.i[5:3];
    assign dst_s = bus.i[8:6];
    assign a_s   = ram_q[bus.a];
    assign b_s   = ram_q[bus.b];

    // Source operand pair selection (R, S).
    always_comb begin
        r_s = {WIDTH{1'b0}};
        s_s = {WIDTH{1'b0}};
        case (src_s)
            3'd0:    begin r_s = a_s;     s_s = q_q; end
            3'd1:    begin r_s = a_s;     s_s = b_s; end
            3'd2:    begin r_s = {WIDTH{1'b0}}; s_s = q_q; end
            3'd3:    begin r_s = {WIDTH{1'b0}}; s_s = b_s; end
            3'd4:    begin r_s = {WIDTH{1'b0}}; s_s = a_s; end
            3'd5:    begin r_s = bus.din; s_s = a_s; end
            3'd6:    begin r_s = bus.din; s_s = q_q; end
            3'd7:    begin r_s = bus.din; s_s = {WIDTH{1'b0}}; end
            default: begin r_s = {WIDTH{1'b0}}; s_s = {WIDTH{1'b0}}; end
        endcase
    end

    // Adder, logic unit and lookahead; the adder runs for every function so the
    // carry flags stay meaningful even when F comes from the logic unit.
    always_comb begin
        r_eff_s = r_s;
        s_eff_s = s_s;
        case (fun_s)
            3'd1:    r_eff_s = ~r_s;
            3'd2:    s_eff_s = ~s_s;
            default: begin r_eff_s = r_s; s_eff_s = s_s; end
        endcase
        sum_s = {1'b0, r_eff_s} + {1'b0, s_eff_s} + {{WIDTH{1'b0}}, bus.cn};
        case (fun_s)
            3'd3:    f_s = r_s | s_s;
            3'd4:    f_s = r_s & s_s;
            3'd5:    f_s = ~r_s & s_s;
            3'd6:    f_s = r_s ^ s_s;
            3'd7:    f_s = ~(r_s ^ s_s);
            default: f_s = sum_s[WIDTH-1:0];
        endcase
        // Ripple the group generate from LSB upward: G = g[k] | p[k] & G(below).
        gg_s = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            gg_s = (r_eff_s[k] & s_eff_s[k]) | ((r_eff_s[k] | s_eff_s[k]) & gg_s);
        end
        g_n_s   = ~gg_s;
        p_n_s   = ~(&(r_eff_s | s_eff_s));
        cn4_s   = sum_s[WIDTH];
        c_msb_s = r_eff_s[WIDTH-1] ^ s_eff_s[WIDTH-1] ^ sum_s[WIDTH-1];
        ovr_s   = c_msb_s ^ cn4_s;
        f0_s    = (f_s == {WIDTH{1'b0}});
        fn_s    = f_s[WIDTH-1];
    end

    assign down_s = (dst_s == 3'd4) || (dst_s == 3'd5);
    assign up_s   = (dst_s == 3'd6) || (dst_s == 3'd7);
    assign y_s    = (dst_s == 3'd2) ? a_s : f_s;

    assign ram0 = down_s ? f_s[0]         : 1'bz;
    assign q0   = down_s ? q_q[0]         : 1'bz;
    assign ramn = up_s   ? f_s[WIDTH-1]   : 1'bz;
    assign qn   = up_s   ? q_q[WIDTH-1]   : 1'bz;
    assign y    = bus.oe_ ? {WIDTH{1'bz}} : y_s;

    assign bus.ovr = ovr_s;
    assign bus.cn4 = cn4_s;
    assign bus.f0  = f0_s;
    assign bus.fn  = fn_s;
    assign bus.g_  = g_n_s;
    assign bus.p_  = p_n_s;
    assign bus.st  = st_q;

    // Next-state for register file, Q and status according to the destination.
    always_comb begin
        ram_d = ram_q;
        q_d   = q_q;
        st_d  = bus.stl ? {ovr_s, cn4_s, fn_s, f0_s} : st_q;
        case (dst_s)
            3'd0:    q_d = f_s;
            3'd2,
            3'd3:    ram_d[bus.b] = f_s;
            3'd4:    begin
                ram_d[bus.b] = {ramn, f_s[WIDTH-1:1]};
                q_d          = {qn, q_q[WIDTH-1:1]};
            end
            3'd5:    ram_d[bus.b] = {ramn, f_s[WIDTH-1:1]};
            3'd6:    begin
                ram_d[bus.b] = {f_s[WIDTH-2:0], ram0};
                q_d          = {q_q[WIDTH-2:0], q0};
            end
            3'd7:    ram_d[bus.b] = {f_s[WIDTH-2:0], ram0};
            default: q_d = q_q;
        endcase
    end

    // State registers; reset clears everything and blocks writes while held.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                ram_q[k] <= {WIDTH{1'b0}};
            end
            q_q  <= {WIDTH{1'b0}};
            st_q <= 4'b0000;
        end else begin
            ram_q <= ram_d;
            q_q   <= q_d;
            st_q  <= st_d;
        end
    end
endmodule

// File: tb/tb_bitslice_alu_n.sv
// Directed bench for bitslice_alu_n at WIDTH=8 and WIDTH=4 with a scoreboard queue.
module tb_bitslice_alu_n;
    logic cp;
    logic rst;

    bitslice_alu_n_if #(.WIDTH(8), .RAM_AW(4)) if8 ();
    bitslice_alu_n_if #(.WIDTH(4), .RAM_AW(4)) if4 ();

    wire [7:0] y8;
    wire [3:0] y4;
    wire q0_8, qn_8, ram0_8, ramn_8;
    wire q0_4, qn_4, ram0_4, ramn_4;
    // Shift port drivers, bit order {ramn, ram0, qn, q0}.
    logic [3:0] en8, dv8, en4, dv4;

    assign ramn_8 = en8[3] ? dv8[3] : 1'bz;
    assign ram0_8 = en8[2] ? dv8[2] : 1'bz;
    assign qn_8   = en8[1] ? dv8[1] : 1'bz;
    assign q0_8   = en8[0] ? dv8[0] : 1'bz;
    assign ramn_4 = en4[3] ? dv4[3] : 1'bz;
    assign ram0_4 = en4[2] ? dv4[2] : 1'bz;
    assign qn_4   = en4[1] ? dv4[1] : 1'bz;
    assign q0_4   = en4[0] ? dv4[0] : 1'bz;

    // Pull-ups make a released y bus read as all ones.
    for (genvar k = 0; k < 8; k++) begin : g_pu8
        pullup (y8[k]);
    end
    for (genvar k = 0; k < 4; k++) begin : g_pu4
        pullup (y4[k]);
    end

    bitslice_alu_n #(.WIDTH(8), .RAM_AW(4)) dut8 (
        .cp(cp), .rst(rst), .bus(if8.slave),
        .q0(q0_8), .qn(qn_8), .ram0(ram0_8), .ramn(ramn_8), .y(y8)
    );
    bitslice_alu_n #(.WIDTH(4), .RAM_AW(4)) dut4 (
        .cp(cp), .rst(rst), .bus(if4.slave),
        .q0(q0_4), .qn(qn_4), .ram0(ram0_4), .ramn(ramn_4), .y(y4)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic [31:0] oy(input bit w4);
        return w4 ? {28'h0, y4} : {24'h0, y8};
    endfunction
    function automatic logic [31:0] oflags(input bit w4);
        return w4 ? {28'h0, if4.ovr, if4.cn4, if4.fn, if4.f0}
                  : {28'h0, if8.ovr, if8.cn4, if8.fn, if8.f0};
    endfunction
    function automatic logic [31:0] ost(input bit w4);
        return w4 ? {28'h0, if4.st} : {28'h0, if8.st};
    endfunction
    function automatic logic [31:0] oshift(input bit w4);
        return w4 ? {28'h0, ramn_4, ram0_4, qn_4, q0_4}
                  : {28'h0, ramn_8, ram0_8, qn_8, q0_8};
    endfunction
    function automatic logic [31:0] olap();
        return {30'h0, if8.g_, if8.p_};
    endfunction

    task automatic drv(input bit w4, input logic [8:0] ii, input logic [3:0] aa,
                       input logic [3:0] bb, input logic [7:0] dd,
                       input logic cc, input logic ss);
        if (w4) begin
            if4.i = ii; if4.a = aa; if4.b = bb; if4.din = dd[3:0]; if4.cn = cc; if4.stl = ss;
        end else begin
            if8.i = ii; if8.a = aa; if8.b = bb; if8.din = dd;      if8.cn = cc; if8.stl = ss;
        end
    endtask

    task automatic edge_t();
        @(posedge cp);
        #1;
    endtask

    // Read a register through ZA/ADD with cn=0 and a NOP destination.
    task automatic rd(input bit w4, input logic [3:0] addr, input string tag, input logic [7:0] exp);
        drv(w4, 9'o104, addr, 4'd0, 8'h00, 1'b0, 1'b0);
        push(tag, {24'h0, exp});
        @(negedge cp);
        pop_check(oy(w4));
        edge_t();
    endtask

    // Read Q through ZQ/ADD with cn=0 and a NOP destination.
    task automatic rdq(input bit w4, input string tag, input logic [7:0] exp);
        drv(w4, 9'o102, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
        push(tag, {24'h0, exp});
        @(negedge cp);
        pop_check(oy(w4));
        edge_t();
    endtask

    initial begin
        rst = 1'b0;
        en8 = 4'b0000; dv8 = 4'b0000; en4 = 4'b0000; dv4 = 4'b0000;
        if8.oe_ = 1'b0; if4.oe_ = 1'b0;
        drv(1'b0, 9'o104, 4'd1, 4'd0, 8'h00, 1'b0, 1'b0);
        drv(1'b1, 9'o104, 4'd1, 4'd0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge cp);
        #3;
        // Reset asserted mid-cycle: state clears without waiting for an edge.
        rst = 1'b1;
        #1;
        push("rst_st8", 32'h0);          pop_check(ost(1'b0));
        push("rst_st4", 32'h0);          pop_check(ost(1'b1));
        push("rst_y8", 32'h00);          pop_check(oy(1'b0));
        push("rst_flags8", 32'h1);       pop_check(oflags(1'b0));
        drv(1'b0, 9'o307, 4'd0, 4'd1, 8'h77, 1'b0, 1'b0);
        @(posedge cp);
        #3;
        rst = 1'b0;
        rd(1'b0, 4'd1, "rst_write_blocked", 8'h00);
        rdq(1'b0, "rst_q8", 8'h00);

        // Load and add, 8 bit.
        drv(1'b0, 9'o307, 4'd0, 4'd3, 8'h5A, 1'b0, 1'b0); edge_t();
        drv(1'b0, 9'o301, 4'd3, 4'd3, 8'h00, 1'b0, 1'b0);
        push("add_y8", 32'hB4); push("add_flags8", 32'hA);
        @(negedge cp); pop_check(oy(1'b0)); pop_check(oflags(1'b0));
        edge_t();
        rd(1'b0, 4'd3, "add_wb8", 8'hB4);

        // Subtract to zero with status latch, then hold.
        drv(1'b0, 9'o007, 4'd0, 4'd0, 8'h10, 1'b0, 1'b0); edge_t();
        drv(1'b0, 9'o116, 4'd0, 4'd0, 8'h10, 1'b1, 1'b1);
        push("sub_y8", 32'h00); push("sub_flags8", 32'h5);
        @(negedge cp); pop_check(oy(1'b0)); pop_check(oflags(1'b0));
        edge_t();
        push("st_latch8", 32'h5); pop_check(ost(1'b0));
        drv(1'b0, 9'o007, 4'd0, 4'd0, 8'h33, 1'b0, 1'b0); edge_t();
        push("st_hold8", 32'h5); pop_check(ost(1'b0));

        // Double-length down shift.
        drv(1'b0, 9'o307, 4'd0, 4'd2, 8'h81, 1'b0, 1'b0); edge_t();
        drv(1'b0, 9'o007, 4'd0, 4'd0, 8'h03, 1'b0, 1'b0); edge_t();
        drv(1'b0, 9'o433, 4'd0, 4'd2, 8'h00, 1'b0, 1'b0);
        en8 = 4'b1010; dv8 = 4'b1000;
        push("down_ports8", 32'hD);
        @(negedge cp); pop_check(oshift(1'b0));
        edge_t();
        en8 = 4'b0000;
        rd(1'b0, 4'd2, "down_ram8", 8'hC0);
        rdq(1'b0, "down_q8", 8'h01);

        // Up shift, then RAMA shows A on y while writing F.
        drv(1'b0, 9'o307, 4'd0, 4'd5, 8'h80, 1'b0, 1'b0); edge_t();
        drv(1'b0, 9'o733, 4'd0, 4'd5, 8'h00, 1'b0, 1'b0);
        en8 = 4'b0101; dv8 = 4'b0100;
        push("up_ports8", 32'hC);
        @(negedge cp); pop_check(oshift(1'b0));
        edge_t();
        en8 = 4'b0000;
        rd(1'b0, 4'd5, "up_ram8", 8'h01);
        drv(1'b0, 9'o204, 4'd5, 4'd6, 8'h00, 1'b1, 1'b0);
        push("rama_y8", 32'h01); push("rama_flags8", 32'h0);
        @(negedge cp); pop_check(oy(1'b0)); pop_check(oflags(1'b0));
        edge_t();
        rd(1'b0, 4'd6, "rama_wb8", 8'h02);

        // Lookahead: full propagate, then an internal generate.
        drv(1'b0, 9'o107, 4'd0, 4'd0, 8'hFF, 1'b1, 1'b0);
        push("lap_prop8", 32'h2); push("lap_prop_flags8", 32'h5);
        @(negedge cp); pop_check(olap()); pop_check(oflags(1'b0));
        edge_t();
        drv(1'b0, 9'o105, 4'd2, 4'd0, 8'h40, 1'b0, 1'b0);
        push("lap_gen8", 32'h1); push("lap_gen_y8", 32'h00);
        @(negedge cp); pop_check(olap()); pop_check(oy(1'b0));
        edge_t();

        // Output disable releases y.
        drv(1'b0, 9'o107, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0);
        if8.oe_ = 1'b1;
        push("tristate_y8", 32'hFF); push("tristate_flags8", 32'h1);
        @(negedge cp); pop_check(oy(1'b0)); pop_check(oflags(1'b0));
        edge_t();
        if8.oe_ = 1'b0;

        // WIDTH=4 instance: same scenarios with truncated data.
        drv(1'b1, 9'o307, 4'd0, 4'd3, 8'h0A, 1'b0, 1'b0); edge_t();
        drv(1'b1, 9'o301, 4'd3, 4'd3, 8'h00, 1'b0, 1'b0);
        push("add_y4", 32'h4); push("add_flags4", 32'hC);
        @(negedge cp); pop_check(oy(1'b1)); pop_check(oflags(1'b1));
        edge_t();
        rd(1'b1, 4'd3, "add_wb4", 8'h04);

        drv(1'b1, 9'o007, 4'd0, 4'd0, 8'h01, 1'b0, 1'b0); edge_t();
        drv(1'b1, 9'o116, 4'd0, 4'd0, 8'h01, 1'b1, 1'b1);
        push("sub_y4", 32'h0); push("sub_flags4", 32'h5);
        @(negedge cp); pop_check(oy(1'b1)); pop_check(oflags(1'b1));
        edge_t();
        push("st_latch4", 32'h5); pop_check(ost(1'b1));

        drv(1'b1, 9'o307, 4'd0, 4'd2, 8'h09, 1'b0, 1'b0); edge_t();
        drv(1'b1, 9'o007, 4'd0, 4'd0, 8'h03, 1'b0, 1'b0); edge_t();
        drv(1'b1, 9'o433, 4'd0, 4'd2, 8'h00, 1'b0, 1'b0);
        en4 = 4'b1010; dv4 = 4'b1000;
        push("down_ports4", 32'hD);
        @(negedge cp); pop_check(oshift(1'b1));
        edge_t();
        en4 = 4'b0000;
        rd(1'b1, 4'd2, "down_ram4", 8'h0C);
        rdq(1'b1, "down_q4", 8'h01);

        drv(1'b1, 9'o307, 4'd0, 4'd5, 8'h08, 1'b0, 1'b0); edge_t();
        drv(1'b1, 9'o733, 4'd0, 4'd5, 8'h00, 1'b0, 1'b0);
        en4 = 4'b0101; dv4 = 4'b0100;
        push("up_ports4", 32'hC);
        @(negedge cp); pop_check(oshift(1'b1));
        edge_t();
        en4 = 4'b0000;
        rd(1'b1, 4'd5, "up_ram4", 8'h01);

        if (sb.size() != 0) begin
            bad++;
            $error("FAIL scoreboard_leftover: observed %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
